instr_fetch_unit: RTL and testbench

//  Fetch stage that sits directly upstream of the KGP_RISC core and supplies its 32-bit instruction input.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          PC_W         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // One fetched word tagged with the byte PC it was read from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Redirect targets must be word aligned; low bits flag a bad target
    function automatic logic misaligned(input logic [PC_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Head is presented from registered storage; when empty the last
// presented head is held so outputs never go X.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  hold_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & valid_o;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;

    // Pointer / occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; only read while occupied, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Track the currently shown head so an empty FIFO keeps showing it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          hold_q <= '0;
        else if (valid_o) hold_q <= mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the core: owns the PC, issues ROM reads, buffers
// returned words with their PC and hands them out via valid/ready.
// Redirects flush buffered and in-flight words and refetch from target.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          IMEM_AW    = 10,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misalign_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] inflight_pc_q;
    logic            inflight_q;
    logic            misalign_q;
    logic [PC_W-1:0] pp4_hold_q;

    logic            pop, issue, push;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    push_entry, head;

    assign pop = instr_valid & instr_ready;

    // Issue only if the word can be guaranteed a slot when it returns
    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect_valid &&
            (int'(fifo_count) + int'(inflight_q) < FIFO_DEPTH + int'(pop)))
            issue = 1'b1;
    end

    // Next fetch PC: redirect target (forced aligned), else advance on issue
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        else if (issue)     fetch_pc_d = fetch_pc_q + 32'd4;
    end

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

    // A returning word is dropped if a redirect lands on its return cycle
    assign push             = inflight_q & ~redirect_valid;
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc_q;

    // PC and in-flight tracking for the 1-cycle ROM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

    // Sticky flag for any misaligned redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          misalign_q <= 1'b0;
        else if (redirect_valid && misaligned(redirect_pc)) misalign_q <= 1'b1;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (instr_valid),
        .count_o     (fifo_count)
    );

    // Keep the link value of the last shown head while the FIFO is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pp4_hold_q <= '0;
        else if (instr_valid) pp4_hold_q <= head.pc + 32'd4;
    end

    assign instruction  = head.instr;
    assign instr_pc     = head.pc;
    assign pc_plus4     = instr_valid ? head.pc + 32'd4 : pp4_hold_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM model returns its own word address.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, instr_ready;
    logic [31:0] redirect_pc;

    logic        imem_en, instr_valid, misalign_err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata, instruction, instr_pc, pc_plus4;

    logic        imem_en_6, instr_valid_6, misalign_err_6;
    logic [9:0]  imem_addr_6;
    logic [31:0] imem_rdata_6, instruction_6, instr_pc_6, pc_plus4_6;
    logic        redirect_valid_6 = 1'b0;
    logic [31:0] redirect_pc_6    = 32'h0;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.IMEM_AW(10), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instruction(instruction), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.IMEM_AW(10), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut6 (
        .clk(clk), .rst(rst), .imem_en(imem_en_6), .imem_addr(imem_addr_6),
        .imem_rdata(imem_rdata_6), .redirect_valid(redirect_valid_6),
        .redirect_pc(redirect_pc_6), .instruction(instruction_6), .instr_pc(instr_pc_6),
        .pc_plus4(pc_plus4_6), .instr_valid(instr_valid_6), .instr_ready(instr_ready),
        .misalign_err(misalign_err_6)
    );

    // Synchronous ROMs: ROM[i] = i, one cycle read latency
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= {22'b0, imem_addr};
        if (imem_en_6) imem_rdata_6 <= {22'b0, imem_addr_6};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Land 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset over two edges, release between edges; caller is then in cycle c0
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
        imem_rdata = 32'h0; imem_rdata_6 = 32'h0;
        #2;
        // Reset state
        chk("rst_en",    {31'b0, imem_en},      32'h0);
        chk("rst_valid", {31'b0, instr_valid},  32'h0);
        chk("rst_instr", instruction,           32'h0);
        chk("rst_pc",    instr_pc,              32'h0);
        chk("rst_pp4",   pc_plus4,              32'h0);
        chk("rst_mis",   {31'b0, misalign_err}, 32'h0);
        chk("rst_en6",   {31'b0, imem_en_6},    32'h0);
        chk("rst_mis6",  {31'b0, misalign_err_6}, 32'h0);

        // ---- 1: streaming with ready=1 (also RESET_PC wrap instance) ----
        do_reset();
        #1;
        chk("t1_c0_en",   {31'b0, imem_en},     32'h1);
        chk("t1_c0_addr", {22'b0, imem_addr},   32'h0);
        chk("t1_c0_vld",  {31'b0, instr_valid}, 32'h0);
        chk("t6_c0_addr", {22'b0, imem_addr_6}, 32'h3FF);
        tick(); #1;
        chk("t1_c1_addr", {22'b0, imem_addr},   32'h1);
        chk("t1_c1_vld",  {31'b0, instr_valid}, 32'h0);
        chk("t6_c1_vld",  {31'b0, instr_valid_6}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t1_vld",   {31'b0, instr_valid}, 32'h1);
            chk("t1_pc",    instr_pc,             32'(4 * i));
            chk("t1_instr", instruction,          32'(i));
            chk("t1_pp4",   pc_plus4,             32'(4 * i + 4));
            chk("t1_addr",  {22'b0, imem_addr},   32'(i + 2));
            chk("t6_vld",   {31'b0, instr_valid_6}, 32'h1);
            chk("t6_pc",    instr_pc_6,           32'hFFFF_FFFC + 32'(4 * i));
            chk("t6_instr", instruction_6,        (i == 0) ? 32'h3FF : 32'(i - 1));
            chk("t6_pp4",   pc_plus4_6,           32'(4 * i));
        end

        // ---- 2: backpressure, then drain ----
        instr_ready = 1'b0;
        do_reset();
        #1;
        chk("t2_c0_en", {31'b0, imem_en}, 32'h1);
        tick(); #1;
        chk("t2_c1_en",   {31'b0, imem_en},   32'h1);
        chk("t2_c1_addr", {22'b0, imem_addr}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("t2_hold_en",  {31'b0, imem_en},     32'h0);
            chk("t2_hold_vld", {31'b0, instr_valid}, 32'h1);
            chk("t2_hold_pc",  instr_pc,             32'h0);
            chk("t2_hold_ins", instruction,          32'h0);
        end
        tick(); instr_ready = 1'b1; #1;
        chk("t2_c5_pc",   instr_pc,           32'h0);
        chk("t2_c5_addr", {22'b0, imem_addr}, 32'h2);
        chk("t2_c5_en",   {31'b0, imem_en},   32'h1);
        tick(); #1;
        chk("t2_c6_vld",  {31'b0, instr_valid}, 32'h1);
        chk("t2_c6_pc",   instr_pc,             32'h4);
        chk("t2_c6_addr", {22'b0, imem_addr},   32'h3);
        tick(); #1;
        chk("t2_c7_vld",  {31'b0, instr_valid}, 32'h1);
        chk("t2_c7_pc",   instr_pc,             32'h8);
        chk("t2_c7_ins",  instruction,          32'h2);

        // ---- 3: redirect with head + one in flight ----
        do_reset();
        tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("t3_rd_pc",  instr_pc,             32'h0);
        chk("t3_rd_vld", {31'b0, instr_valid}, 32'h1);
        chk("t3_rd_en",  {31'b0, imem_en},     32'h0);
        tick(); redirect_valid = 1'b0; #1;
        chk("t3_c3_en",   {31'b0, imem_en},      32'h1);
        chk("t3_c3_addr", {22'b0, imem_addr},    32'h10);
        chk("t3_c3_vld",  {31'b0, instr_valid},  32'h0);
        chk("t3_c3_mis",  {31'b0, misalign_err}, 32'h0);
        chk("t3_c3_hpc",  instr_pc,              32'h0);
        tick(); #1;
        chk("t3_c4_vld",  {31'b0, instr_valid}, 32'h0);
        chk("t3_c4_addr", {22'b0, imem_addr},   32'h11);
        tick(); #1;
        chk("t3_c5_vld",  {31'b0, instr_valid}, 32'h1);
        chk("t3_c5_pc",   instr_pc,             32'h40);
        chk("t3_c5_ins",  instruction,          32'h10);
        chk("t3_c5_pp4",  pc_plus4,             32'h44);

        // ---- 4: misaligned redirect, sticky error ----
        redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
        chk("t4_rd_en", {31'b0, imem_en}, 32'h0);
        tick(); redirect_valid = 1'b0; #1;
        chk("t4_c6_addr", {22'b0, imem_addr},    32'h10);
        chk("t4_c6_mis",  {31'b0, misalign_err}, 32'h1);
        chk("t4_c6_vld",  {31'b0, instr_valid},  32'h0);
        tick(); #1;
        chk("t4_c7_vld",  {31'b0, instr_valid},  32'h0);
        tick(); #1;
        chk("t4_c8_pc",   instr_pc,              32'h40);
        chk("t4_c8_ins",  instruction,           32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick(); redirect_valid = 1'b0; #1;
        chk("t4_c9_addr", {22'b0, imem_addr},    32'h20);
        chk("t4_c9_mis",  {31'b0, misalign_err}, 32'h1);
        tick(); tick(); #1;
        chk("t4_c11_pc",  instr_pc,              32'h80);
        chk("t4_c11_mis", {31'b0, misalign_err}, 32'h1);

        // ---- 5: asynchronous reset mid-stream ----
        tick(); #1;
        chk("t5_pre_pc", instr_pc, 32'h84);
        #3; rst = 1'b1; #1;
        chk("t5_en",    {31'b0, imem_en},      32'h0);
        chk("t5_vld",   {31'b0, instr_valid},  32'h0);
        chk("t5_instr", instruction,           32'h0);
        chk("t5_pc",    instr_pc,              32'h0);
        chk("t5_pp4",   pc_plus4,              32'h0);
        chk("t5_mis",   {31'b0, misalign_err}, 32'h0);
        tick(); rst = 1'b0; #1;
        chk("t5_c0_en",   {31'b0, imem_en},     32'h1);
        chk("t5_c0_addr", {22'b0, imem_addr},   32'h0);
        tick(); #1;
        chk("t5_c1_vld",  {31'b0, instr_valid}, 32'h0);
        tick(); #1;
        chk("t5_c2_vld",  {31'b0, instr_valid}, 32'h1);
        chk("t5_c2_pc",   instr_pc,             32'h0);
        chk("t5_c2_ins",  instruction,          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
